// File: rtl/ram16k_arbiter_pkg.sv
// Shared constants and state encoding for the RAM16K two-port arbiter.
package ram16k_arbiter_pkg;

   localparam int ADDR_W    = 14;
   localparam int DATA_W    = 16;
   localparam int MAX_BURST = 4;

   // Ownership states: IDLE spends one arbitration cycle, OWNx grants port x.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN0 = 2'd1,
      ST_OWN1 = 2'd2
   } state_t;

   // Map a port index to the state that grants it.
   function automatic state_t own_state(input logic idx);
      return idx ? ST_OWN1 : ST_OWN0;
   endfunction

endpackage

// File: rtl/ram16k_arbiter_if.sv
// One requester port of the arbiter: request/command toward the arbiter,
// grant/ack/read data back to the requester.
interface ram16k_arbiter_if #(
   parameter int ADDR_W = ram16k_arbiter_pkg::ADDR_W,
   parameter int DATA_W = ram16k_arbiter_pkg::DATA_W
) ();

   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              gnt;
   logic              ack;
   logic [DATA_W-1:0] rdata;

   // Requester side (CPU or DMA engine).
   modport master (
      output req, we, addr, wdata,
      input  gnt, ack, rdata
   );

   // Arbiter side.
   modport slave (
      input  req, we, addr, wdata,
      output gnt, ack, rdata
   );

endinterface

// File: rtl/ram16k_arbiter_rr_pick2.sv
// Round-robin tie-break between two requesters; the port that did not own
// the RAM most recently wins a simultaneous request.
module rr_pick2 (
   input  logic req0,
   input  logic req1,
   input  logic last,
   output logic valid,
   output logic winner
);

   // Winner is the lone requester, or the opposite of the last owner on a tie.
   always_comb begin
      valid  = req0 | req1;
      winner = 1'b0;
      if (req0 && req1) begin
         winner = ~last;
      end else if (req1) begin
         winner = 1'b1;
      end
   end

endmodule

// File: rtl/ram16k_arbiter.sv
// Two-port arbiter in front of an external RAM16K: round-robin ownership with
// a burst cap, combinational RAM pin drive, registered read data and ack.
module ram16k_arbiter #(
   parameter int ADDR_W    = ram16k_arbiter_pkg::ADDR_W,
   parameter int DATA_W    = ram16k_arbiter_pkg::DATA_W,
   parameter int MAX_BURST = ram16k_arbiter_pkg::MAX_BURST
) (
   input  logic               clock,
   input  logic               reset_n,
   ram16k_arbiter_if.slave    p0,
   ram16k_arbiter_if.slave    p1,
   output logic [DATA_W-1:0]  ram_in,
   output logic [ADDR_W-1:0]  ram_address,
   output logic               ram_load,
   input  logic [DATA_W-1:0]  ram_out,
   output logic               busy
);

   import ram16k_arbiter_pkg::*;

   localparam int CNT_W = $clog2(MAX_BURST) + 1;

   // Port signals gathered into arrays so both ports share one description.
   logic [1:0]        req;
   logic [1:0]        we;
   logic [ADDR_W-1:0] addr  [2];
   logic [DATA_W-1:0] wdata [2];
   logic [1:0]        gnt;
   logic [1:0]        accept;

   state_t            state_reg, state_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic              last_reg, last_next;
   logic [1:0]        ack_reg;
   logic [DATA_W-1:0] rdata_reg [2];

   logic              own_idx;
   logic              other_idx;
   logic [CNT_W-1:0]  cnt_inc;
   logic              cap_hit;
   logic              pick_valid;
   logic              pick_winner;

   assign req[0]   = p0.req;
   assign we[0]    = p0.we;
   assign addr[0]  = p0.addr;
   assign wdata[0] = p0.wdata;
   assign req[1]   = p1.req;
   assign we[1]    = p1.we;
   assign addr[1]  = p1.addr;
   assign wdata[1] = p1.wdata;

   assign p0.gnt   = gnt[0];
   assign p0.ack   = ack_reg[0];
   assign p0.rdata = rdata_reg[0];
   assign p1.gnt   = gnt[1];
   assign p1.ack   = ack_reg[1];
   assign p1.rdata = rdata_reg[1];

   assign busy = (state_reg != ST_IDLE);

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_accept
         assign accept[gi] = req[gi] & gnt[gi];
      end
   endgenerate

   // Burst bookkeeping: this cycle's accept fills the cap when cnt+1 hits it.
   assign own_idx   = (state_reg == ST_OWN1);
   assign other_idx = ~own_idx;
   assign cnt_inc   = cnt_reg + CNT_W'(1);
   assign cap_hit   = (|accept) && (cnt_inc == CNT_W'(MAX_BURST));

   rr_pick2 u_pick (
      .req0   (req[0]),
      .req1   (req[1]),
      .last   (last_reg),
      .valid  (pick_valid),
      .winner (pick_winner)
   );

   // State register: ownership, burst count and last owner.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= '0;
         last_reg  <= 1'b1;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         last_reg  <= last_next;
      end
   end

   // Next-state: arbitrate from IDLE, hand off directly or release from OWNx.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      last_next  = last_reg;
      case (state_reg)
         ST_IDLE: begin
            cnt_next = '0;
            if (pick_valid) begin
               state_next = own_state(pick_winner);
            end
         end
         ST_OWN0, ST_OWN1: begin
            if (req[other_idx] && (!req[own_idx] || cap_hit)) begin
               state_next = own_state(other_idx);
               last_next  = own_idx;
               cnt_next   = '0;
            end else if (!req[own_idx]) begin
               state_next = ST_IDLE;
               last_next  = own_idx;
               cnt_next   = '0;
            end else begin
               // Owner keeps the RAM; an uncontended cap simply restarts the count.
               cnt_next = cap_hit ? '0 : cnt_inc;
            end
         end
         default: begin
            state_next = ST_IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   // Outputs: grants decoded from state, RAM pins steered to the owner.
   always_comb begin
      gnt         = 2'b00;
      ram_address = '0;
      ram_in      = '0;
      ram_load    = 1'b0;
      case (state_reg)
         ST_OWN0: begin
            gnt[0]      = 1'b1;
            ram_address = addr[0];
            ram_in      = wdata[0];
            ram_load    = req[0] & we[0];
         end
         ST_OWN1: begin
            gnt[1]      = 1'b1;
            ram_address = addr[1];
            ram_in      = wdata[1];
            ram_load    = req[1] & we[1];
         end
         default: begin
            gnt = 2'b00;
         end
      endcase
      // No write may land on a reset edge, even if a port is mid-access.
      if (!reset_n) begin
         ram_load = 1'b0;
      end
   end

   // Response registers: one-cycle ack and captured RAM output per accept.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         ack_reg <= 2'b00;
         for (int i = 0; i < 2; i++) begin
            rdata_reg[i] <= '0;
         end
      end else begin
         ack_reg <= accept;
         for (int i = 0; i < 2; i++) begin
            if (accept[i]) begin
               rdata_reg[i] <= ram_out;
            end
         end
      end
   end

   // Ownership is exclusive and the state never leaves the three legal codes.
   a_gnt_exclusive: assert property (@(posedge clock) disable iff (!reset_n)
      !(gnt[0] && gnt[1]));
   a_state_legal: assert property (@(posedge clock) disable iff (!reset_n)
      (state_reg == ST_IDLE) || (state_reg == ST_OWN0) || (state_reg == ST_OWN1));

endmodule

// File: tb/tb_ram16k_arbiter.sv
// Bench for ram16k_arbiter with a behavioural RAM16K and reference model.
module tb_ram16k_arbiter;

   import ram16k_arbiter_pkg::*;

   localparam int AW = ADDR_W;
   localparam int DW = DATA_W;
   localparam int MB = MAX_BURST;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   ram16k_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) p0_if ();
   ram16k_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) p1_if ();

   logic [DW-1:0] ram_in;
   logic [DW-1:0] ram_out;
   logic [AW-1:0] ram_address;
   logic          ram_load;
   logic          busy;

   ram16k_arbiter dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .p0          (p0_if),
      .p1          (p1_if),
      .ram_in      (ram_in),
      .ram_address (ram_address),
      .ram_load    (ram_load),
      .ram_out     (ram_out),
      .busy        (busy)
   );

   // External RAM16K: combinational read, write on rising edge; bench preload port.
   logic [DW-1:0] ram_mem [1<<AW];
   logic          pre_en   = 1'b0;
   logic [AW-1:0] pre_addr = '0;
   logic [DW-1:0] pre_data = '0;
   assign ram_out = ram_mem[ram_address];
   always @(posedge clock) begin
      if (ram_load) ram_mem[ram_address] <= ram_in;
      else if (pre_en) ram_mem[pre_addr] <= pre_data;
   end

   // Reference model: owner -1 = nobody, run = accepts in this ownership.
   int            m_owner = -1;
   int            m_run   = 0;
   int            m_last  = 1;
   logic          m_ack   [2];
   logic [DW-1:0] m_rdata [2];
   logic          m_acc   [2];
   logic [DW-1:0] m_mem   [1<<AW];

   int checks = 0;
   int errors = 0;

   function automatic logic in_req(int p);
      return (p == 1) ? p1_if.req : p0_if.req;
   endfunction
   function automatic logic in_we(int p);
      return (p == 1) ? p1_if.we : p0_if.we;
   endfunction
   function automatic logic [AW-1:0] in_addr(int p);
      return (p == 1) ? p1_if.addr : p0_if.addr;
   endfunction
   function automatic logic [DW-1:0] in_wdata(int p);
      return (p == 1) ? p1_if.wdata : p0_if.wdata;
   endfunction

   function automatic logic [AW-1:0] rand_addr();
      int k = $urandom_range(0, 16);
      return (k == 16) ? AW'(16383) : AW'(k);
   endfunction

   task automatic set_port(int p, logic r, logic w, logic [AW-1:0] a, logic [DW-1:0] d);
      if (p == 0) begin
         p0_if.req = r; p0_if.we = w; p0_if.addr = a; p0_if.wdata = d;
      end else begin
         p1_if.req = r; p1_if.we = w; p1_if.addr = a; p1_if.wdata = d;
      end
   endtask

   // Advance one clock, stepping the model with the inputs present at the edge.
   task automatic tick();
      logic          r [2];
      logic          w [2];
      logic [AW-1:0] a [2];
      logic [DW-1:0] d [2];
      logic          rst_n;
      logic          pe;
      logic [AW-1:0] pa;
      logic [DW-1:0] pd;
      int            x, y, after;
      for (int p = 0; p < 2; p++) begin
         r[p] = in_req(p); w[p] = in_we(p); a[p] = in_addr(p); d[p] = in_wdata(p);
      end
      rst_n = reset_n; pe = pre_en; pa = pre_addr; pd = pre_data;
      @(posedge clock);
      if (pe) m_mem[pa] = pd;
      if (!rst_n) begin
         m_owner = -1; m_run = 0; m_last = 1;
         for (int p = 0; p < 2; p++) begin
            m_ack[p] = 1'b0; m_rdata[p] = '0; m_acc[p] = 1'b0;
         end
      end else begin
         for (int p = 0; p < 2; p++) begin
            m_acc[p] = (m_owner == p) && r[p];
            m_ack[p] = m_acc[p];
            if (m_acc[p]) begin
               m_rdata[p] = m_mem[a[p]];
               if (w[p]) m_mem[a[p]] = d[p];
            end
         end
         if (m_owner < 0) begin
            if (r[0] && r[1]) m_owner = 1 - m_last;
            else if (r[0]) m_owner = 0;
            else if (r[1]) m_owner = 1;
            m_run = 0;
         end else begin
            x = m_owner; y = 1 - x;
            after = m_run + (m_acc[x] ? 1 : 0);
            if (r[y] && (!r[x] || (m_acc[x] && after == MB))) begin
               m_owner = y; m_last = x; m_run = 0;
            end else if (!r[x]) begin
               m_owner = -1; m_last = x; m_run = 0;
            end else begin
               m_run = (after == MB) ? 0 : after;
            end
         end
      end
      #1;
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      set_port(0, 1'b0, 1'b0, '0, '0);
      set_port(1, 1'b0, 1'b0, '0, '0);
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      @(negedge clock);
      checks++;
      if ({p0_if.gnt, p1_if.gnt, busy} !== 3'b000) begin
         errors++; $display("FAIL reset_gnt_busy got %b want 000", {p0_if.gnt, p1_if.gnt, busy});
      end
      checks++;
      if ({p0_if.ack, p1_if.ack, ram_load} !== 3'b000) begin
         errors++; $display("FAIL reset_ack_load got %b want 000", {p0_if.ack, p1_if.ack, ram_load});
      end
      checks++;
      if (p0_if.rdata !== 16'h0 || p1_if.rdata !== 16'h0 || ram_address !== '0) begin
         errors++; $display("FAIL reset_data got %h %h %h want 0 0 0", p0_if.rdata, p1_if.rdata, ram_address);
      end
      $display("reset: gnt=%b%b busy=%b ack=%b%b", p0_if.gnt, p1_if.gnt, busy, p0_if.ack, p1_if.ack);
      tick();
   endtask

   // Give every location the random tests touch a known value (0..9 = 100..109).
   task automatic test_preload();
      for (int i = 0; i < 18; i++) begin
         pre_en   = 1'b1;
         pre_addr = (i < 16) ? AW'(i) : ((i == 16) ? AW'(2048) : AW'(16383));
         pre_data = (i < 10) ? DW'(100 + i) : DW'($urandom);
         tick();
      end
      pre_en = 1'b0;
      tick();
      $display("preload: 18 locations written");
   endtask

   task automatic test_single_write();
      logic [DW-1:0] old;
      old = m_mem[2048];
      set_port(0, 1'b1, 1'b1, AW'(2048), DW'(15));
      @(negedge clock);
      checks++;
      if (p0_if.gnt !== 1'b0) begin errors++; $display("FAIL wr_arb_cycle gnt0 got %b want 0", p0_if.gnt); end
      tick();
      @(negedge clock);
      checks++;
      if (p0_if.gnt !== 1'b1 || ram_load !== 1'b1 || ram_address !== AW'(2048) || ram_in !== DW'(15)) begin
         errors++; $display("FAIL wr_grant got gnt=%b load=%b addr=%0d in=%0d want 1 1 2048 15",
                             p0_if.gnt, ram_load, ram_address, ram_in);
      end
      tick();
      set_port(0, 1'b0, 1'b0, '0, '0);
      @(negedge clock);
      checks++;
      if (p0_if.ack !== 1'b1 || p0_if.rdata !== old || ram_load !== 1'b0) begin
         errors++; $display("FAIL wr_ack got ack=%b rdata=%h load=%b want 1 %h 0", p0_if.ack, p0_if.rdata, ram_load, old);
      end
      checks++;
      if (ram_mem[2048] !== DW'(15)) begin errors++; $display("FAIL wr_ram got %0d want 15", ram_mem[2048]); end
      $display("write 2048<=15: ack=%b pre=%h", p0_if.ack, p0_if.rdata);
      tick();
      set_port(0, 1'b1, 1'b0, AW'(2048), '0);
      tick();
      tick();
      set_port(0, 1'b0, 1'b0, '0, '0);
      @(negedge clock);
      checks++;
      if (p0_if.ack !== 1'b1 || p0_if.rdata !== DW'(15)) begin
         errors++; $display("FAIL rd_back got ack=%b rdata=%0d want 1 15", p0_if.ack, p0_if.rdata);
      end
      $display("read 2048: ack=%b rdata=%0d", p0_if.ack, p0_if.rdata);
      tick();
   endtask

   task automatic test_tie_rr();
      logic [DW-1:0] v [2];
      int            own, prev;
      apply_reset();
      v[0] = m_mem[5];
      v[1] = m_mem[6];
      set_port(0, 1'b1, 1'b0, AW'(5), '0);
      set_port(1, 1'b1, 1'b0, AW'(6), '0);
      for (int c = 0; c < 25; c++) begin
         @(negedge clock);
         own = (c == 0) ? -1 : ((c - 1) / MB) % 2;
         checks++;
         if (p0_if.gnt !== (own == 0) || p1_if.gnt !== (own == 1)) begin
            errors++; $display("FAIL tie_gnt c=%0d got %b%b want owner %0d", c, p0_if.gnt, p1_if.gnt, own);
         end
         if (c >= 2) begin
            prev = ((c - 2) / MB) % 2;
            checks++;
            if (p0_if.ack !== (prev == 0) || p1_if.ack !== (prev == 1)) begin
               errors++; $display("FAIL tie_ack c=%0d got %b%b want port %0d", c, p0_if.ack, p1_if.ack, prev);
            end
            checks++;
            if (((prev == 0) ? p0_if.rdata : p1_if.rdata) !== v[prev]) begin
               errors++; $display("FAIL tie_rdata c=%0d port %0d got %h want %h", c, prev,
                                   (prev == 0) ? p0_if.rdata : p1_if.rdata, v[prev]);
            end
         end
         $display("tie c=%0d gnt=%b%b ack=%b%b", c, p0_if.gnt, p1_if.gnt, p0_if.ack, p1_if.ack);
         tick();
      end
      set_port(0, 1'b0, 1'b0, '0, '0);
      set_port(1, 1'b0, 1'b0, '0, '0);
      tick();
      tick();
   endtask

   task automatic test_burst();
      for (int c = 0; c < 12; c++) begin
         set_port(1, c <= 10, 1'b0, (c >= 1 && c <= 10) ? AW'(c - 1) : '0, '0);
         @(negedge clock);
         if (c >= 1 && c <= 10) begin
            checks++;
            if (p1_if.gnt !== 1'b1 || p0_if.gnt !== 1'b0) begin
               errors++; $display("FAIL burst_gnt c=%0d got %b%b want 01", c, p0_if.gnt, p1_if.gnt);
            end
         end
         if (c >= 2) begin
            checks++;
            if (p1_if.ack !== 1'b1 || p1_if.rdata !== DW'(100 + c - 2)) begin
               errors++; $display("FAIL burst_ack c=%0d got ack=%b rdata=%0d want 1 %0d", c, p1_if.ack, p1_if.rdata, 100 + c - 2);
            end
         end
         $display("burst c=%0d gnt1=%b ack1=%b rdata1=%0d", c, p1_if.gnt, p1_if.ack, p1_if.rdata);
         tick();
      end
      set_port(1, 1'b0, 1'b0, '0, '0);
      tick();
   endtask

   task automatic test_conflict();
      apply_reset();
      pre_en = 1'b1; pre_addr = AW'(16383); pre_data = 16'h0ABC;
      tick();
      pre_en = 1'b0;
      set_port(0, 1'b1, 1'b1, AW'(16383), 16'h1111);
      set_port(1, 1'b1, 1'b1, AW'(16383), 16'h2222);
      tick();
      @(negedge clock);
      checks++;
      if (p0_if.gnt !== 1'b1 || ram_load !== 1'b1) begin
         errors++; $display("FAIL conf_first got gnt0=%b load=%b want 1 1", p0_if.gnt, ram_load);
      end
      tick();
      set_port(0, 1'b0, 1'b0, '0, '0);
      @(negedge clock);
      checks++;
      if (p0_if.ack !== 1'b1 || p0_if.rdata !== 16'h0ABC) begin
         errors++; $display("FAIL conf_pre0 got ack=%b rdata=%h want 1 0abc", p0_if.ack, p0_if.rdata);
      end
      tick();
      @(negedge clock);
      checks++;
      if (p1_if.gnt !== 1'b1 || ram_load !== 1'b1) begin
         errors++; $display("FAIL conf_second got gnt1=%b load=%b want 1 1", p1_if.gnt, ram_load);
      end
      tick();
      set_port(1, 1'b0, 1'b0, '0, '0);
      @(negedge clock);
      checks++;
      if (p1_if.ack !== 1'b1 || p1_if.rdata !== 16'h1111) begin
         errors++; $display("FAIL conf_pre1 got ack=%b rdata=%h want 1 1111", p1_if.ack, p1_if.rdata);
      end
      tick();
      checks++;
      if (ram_mem[16383] !== 16'h2222) begin
         errors++; $display("FAIL conf_final got %h want 2222", ram_mem[16383]);
      end
      $display("conflict 16383: final=%h", ram_mem[16383]);
   endtask

   task automatic test_reset_mid();
      logic [DW-1:0] old;
      old = m_mem[1];
      set_port(0, 1'b1, 1'b1, AW'(1), 16'hBEEF);
      tick();
      reset_n = 1'b0;
      @(negedge clock);
      checks++;
      if (p0_if.gnt !== 1'b1 || ram_load !== 1'b0) begin
         errors++; $display("FAIL rstmid_load got gnt0=%b load=%b want 1 0", p0_if.gnt, ram_load);
      end
      tick();
      reset_n = 1'b1;
      set_port(0, 1'b0, 1'b0, '0, '0);
      @(negedge clock);
      checks++;
      if ({p0_if.gnt, p1_if.gnt, busy, p0_if.ack, p1_if.ack} !== 5'b00000) begin
         errors++; $display("FAIL rstmid_ctrl got %b want 00000", {p0_if.gnt, p1_if.gnt, busy, p0_if.ack, p1_if.ack});
      end
      checks++;
      if (p0_if.rdata !== '0 || p1_if.rdata !== '0 || ram_mem[1] !== old) begin
         errors++; $display("FAIL rstmid_data got %h %h ram1=%h want 0 0 %h", p0_if.rdata, p1_if.rdata, ram_mem[1], old);
      end
      $display("reset mid-write: ram[1]=%h ack0=%b", ram_mem[1], p0_if.ack);
      tick();
   endtask

   task automatic test_withdraw();
      for (int c = 0; c < 11; c++) begin
         set_port(0, c <= 8, 1'b0, AW'(3), '0);
         set_port(1, c == 3, 1'b0, AW'(4), '0);
         @(negedge clock);
         if (c >= 1 && c <= 8) begin
            checks++;
            if (p0_if.gnt !== 1'b1 || p1_if.gnt !== 1'b0) begin
               errors++; $display("FAIL wd_gnt c=%0d got %b%b want 10", c, p0_if.gnt, p1_if.gnt);
            end
         end
         checks++;
         if (p1_if.ack !== 1'b0) begin errors++; $display("FAIL wd_ack1 c=%0d got %b want 0", c, p1_if.ack); end
         if (c >= 9) begin
            checks++;
            if (busy !== (c == 9)) begin
               errors++; $display("FAIL wd_busy c=%0d got %b want %b", c, busy, c == 9);
            end
         end
         $display("withdraw c=%0d gnt=%b%b ack=%b%b busy=%b", c, p0_if.gnt, p1_if.gnt, p0_if.ack, p1_if.ack, busy);
         tick();
      end
   endtask

   task automatic test_random();
      int            own;
      logic          exp_load;
      logic [AW-1:0] exp_addr;
      logic [DW-1:0] exp_in;
      apply_reset();
      for (int c = 0; c < 400; c++) begin
         for (int p = 0; p < 2; p++) begin
            if (in_req(p) && !m_acc[p]) begin
               if ($urandom_range(0, 15) == 0) set_port(p, 1'b0, 1'b0, '0, '0);
            end else if ($urandom_range(0, 2) != 0) begin
               set_port(p, 1'b1, 1'($urandom_range(0, 1)), rand_addr(), DW'($urandom));
            end else begin
               set_port(p, 1'b0, 1'b0, '0, '0);
            end
         end
         reset_n = ($urandom_range(0, 99) != 0);
         @(negedge clock);
         own      = m_owner;
         exp_load = reset_n && own >= 0 && in_req(own) && in_we(own);
         exp_addr = (own >= 0) ? in_addr(own) : '0;
         exp_in   = (own >= 0) ? in_wdata(own) : '0;
         checks++;
         if (p0_if.gnt !== (own == 0) || p1_if.gnt !== (own == 1) || busy !== (own >= 0)) begin
            errors++; $display("FAIL rnd_gnt c=%0d got %b%b busy=%b want owner %0d", c, p0_if.gnt, p1_if.gnt, busy, own);
         end
         checks++;
         if (p0_if.ack !== m_ack[0] || p1_if.ack !== m_ack[1]) begin
            errors++; $display("FAIL rnd_ack c=%0d got %b%b want %b%b", c, p0_if.ack, p1_if.ack, m_ack[0], m_ack[1]);
         end
         checks++;
         if (p0_if.rdata !== m_rdata[0] || p1_if.rdata !== m_rdata[1]) begin
            errors++; $display("FAIL rnd_rdata c=%0d got %h %h want %h %h", c, p0_if.rdata, p1_if.rdata, m_rdata[0], m_rdata[1]);
         end
         checks++;
         if (ram_load !== exp_load || ram_address !== exp_addr || ram_in !== exp_in) begin
            errors++; $display("FAIL rnd_pins c=%0d got %b %0d %h want %b %0d %h", c, ram_load, ram_address, ram_in,
                                exp_load, exp_addr, exp_in);
         end
         $display("rnd c=%0d rst_n=%b req=%b%b gnt=%b%b ack=%b%b", c, reset_n, in_req(0), in_req(1),
                  p0_if.gnt, p1_if.gnt, p0_if.ack, p1_if.ack);
         tick();
      end
      reset_n = 1'b1;
      set_port(0, 1'b0, 1'b0, '0, '0);
      set_port(1, 1'b0, 1'b0, '0, '0);
      tick();
      tick();
      for (int i = 0; i < 17; i++) begin
         logic [AW-1:0] a;
         a = (i == 16) ? AW'(16383) : AW'(i);
         checks++;
         if (ram_mem[a] !== m_mem[a]) begin
            errors++; $display("FAIL rnd_mem addr=%0d got %h want %h", a, ram_mem[a], m_mem[a]);
         end
      end
   endtask

   initial begin
      set_port(0, 1'b0, 1'b0, '0, '0);
      set_port(1, 1'b0, 1'b0, '0, '0);
      for (int p = 0; p < 2; p++) begin
         m_ack[p] = 1'b0; m_rdata[p] = '0; m_acc[p] = 1'b0;
      end
      test_reset();
      test_preload();
      test_single_write();
      test_tie_rr();
      test_burst();
      test_conflict();
      test_reset_mid();
      test_withdraw();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Safety net so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ram16k_arbiter.md
Name: ram16k_arbiter

Overview:
- Two-requester arbiter that shares one RAM16K (16-bit data, 14-bit address; combinational read of out from address; write on rising clock edge when load=1) between a CPU data port (port 0) and a DMA/screen-refresh engine (port 1).
- Uses a valid/grant handshake per port, with round-robin ownership and a burst cap so neither port starves.
- Drives the RAM16K in/address/load pins and returns registered read data with a one-cycle ack.

Parameters:
ADDR_W, 14, RAM address width (RAM16K depth 16384).
DATA_W, 16, data width.
MAX_BURST, 4, maximum consecutive accepted accesses by one owner while the other port is requesting.

Ports:
clock  input  1  system clock; all state changes on rising edge.
reset_n  input  1  synchronous, active-low reset.
req0  input  1  port 0 access request; held with addr0/we0/wdata0 stable until accepted.
we0  input  1  port 0 write enable (1=write, 0=read).
addr0  input  ADDR_W  port 0 address.
wdata0  input  DATA_W  port 0 write data.
gnt0  output  1  port 0 owns the RAM this cycle; accept0 = req0 & gnt0.
ack0  output  1  registered; high one cycle after accept0.
rdata0  output  DATA_W  registered read data, valid while ack0=1.
req1, we1, addr1, wdata1, gnt1, ack1, rdata1: same as port 0, for port 1.
ram_in  output  DATA_W  to RAM16K in.
ram_address  output  ADDR_W  to RAM16K address.
ram_load  output  1  to RAM16K load.
ram_out  input  DATA_W  from RAM16K out.
busy  output  1  state != IDLE.

Behaviour:
- States: IDLE, OWN0, OWN1. gntX = (state==OWNX), decoded combinationally from the state register. Never both high.
- Reset (reset_n=0 at an edge): state=IDLE, cnt=0, last=1 (port 0 wins the first tie), ack0=ack1=0, rdata0=rdata1=0. While reset_n=0, ram_load is forced to 0 combinationally, so no write occurs at the reset edge.
- Datapath (combinational):
  - OWNx: ram_address=addrX, ram_in=wdataX, ram_load=reqX&weX.
  - IDLE: ram_address=0, ram_in=0, ram_load=0.
- Access timing:
  - acceptX in cycle N: a write commits at the edge ending N; rdataX captures ram_out at that same edge.
  - ackX=1 and rdataX valid in cycle N+1.
  - A write also captures ram_out, i.e. the pre-write contents.
  - rdataX holds its value when there is no accept.
  - Back-to-back accepts give 1 access per cycle.
- cnt (width clog2(MAX_BURST)+1) counts accepts in the current ownership. It resets to 0 on any state change, and to 0 on reaching MAX_BURST when staying.
- IDLE transitions, evaluated per edge:
  - req0&req1: go to OWN(~last).
  - Only reqX: go to OWNX.
  - Neither: stay IDLE.
  - IDLE costs 1 arbitration cycle before the first grant.
- OWNx transitions, with y = the other port, evaluated per edge:
  - reqY and (!reqX or the accept this cycle makes cnt==MAX_BURST): go to OWNY, last=x, cnt=0. Direct hand-off, no IDLE bubble.
  - Else !reqX: go to IDLE, last=x.
  - Else: stay. cnt increments on accept; on reaching MAX_BURST with reqY=0, cnt=0 and ownership is kept.
- Requests that drop before being accepted are legal: the arbiter simply moves on and no ack is produced.
- Both ports addressing the same location: writes are serialized in grant order, so the last granted writer wins.
- Reset mid-burst: the pending ack is cleared; an access whose accept cycle coincided with reset_n=0 is not performed and not acked.
- Address wrap: addresses are used unmodified; 16383 is valid and there is no overflow logic.

Decomposition:
- Shared package/include (alongside the chapter-03 definitions): ADDR_W/DATA_W constants, state encodings ST_IDLE=2'd0, ST_OWN0=2'd1, ST_OWN1=2'd2.
- One natural sub-module, rr_pick2: combinational round-robin tie-break (req0, req1, last) -> winner index. Used in IDLE.
- RAM16K stays external and is instantiated beside the arbiter in the memory top level and bench.

Test Plan:
- Reset then single write: req0=1, we0=1, addr0=2048, wdata0=15 -> gnt0 the cycle after the request; ram_load=1 for one cycle; ack0 the next cycle. Then read addr0=2048 -> rdata0=15 with ack0.
- Tie after reset: req0=req1=1 (both reads) -> OWN0 first. After 4 accepts (MAX_BURST), hand-off directly to OWN1 with no IDLE cycle; port 1 then gets 4 accepts; alternation continues.
- Uncontended burst: port 1 reads addresses 0,1,2,...,9 continuously -> 10 consecutive acks, no ownership loss past MAX_BURST, rdata1 matches preloaded values 100..109.
- Same-address conflict: port 0 writes 0x1111 and port 1 writes 0x2222 to address 16383 simultaneously -> final RAM value follows grant order (0x2222 after reset tie-break); each write's rdata shows the pre-write contents.
- Reset mid-burst: reset_n=0 during the cycle port 0 is accepted writing 0xBEEF to addr 1 -> ram_load=0, RAM[1] unchanged, ack0=0, state IDLE, gnt0=gnt1=0, rdata0=rdata1=0.
- Request withdrawal: req1 high for 1 cycle while port 0 owns and streams -> no ack1, port 0 keeps ownership; busy drops to 0 one edge after both requests go low.
